full_adder_using_half_adders: RTL and testbench

- Full adder built structurally from half adders, with an optional registered copy of the result.
- Primary outputs Sum/Carry are purely combinational from A, B, C; they settle within the same delta/propagation time, with no clock involvement.
- A WIDTH parameter generalises the block to a ripple-carry adder. The default WIDTH=1 is the classic 1-bit full adder.
- Used as a leaf arithmetic cell in datapaths and as a structural-composition reference.

---
 rtl/full_adder_using_half_adders_pkg.sv | 7 +
 rtl/full_adder_using_half_adders_half_adder.sv | 12 +
 rtl/full_adder_using_half_adders.sv | 57 +++++
 tb/tb_full_adder_using_half_adders.sv | 129 ++++++++++++
 4 files changed

// File: rtl/full_adder_using_half_adders_pkg.sv
// Shared constants for the half-adder based full adder / ripple adder.
// Holds the default operand width used by the top-level parameter.
package full_adder_using_half_adders_pkg;

    localparam int DEFAULT_WIDTH = 1;

endpackage

// File: rtl/full_adder_using_half_adders_half_adder.sv
// Half adder leaf cell: two single-bit inputs give a sum and a carry.
module half_adder (
    input  logic a,
    input  logic b,
    output logic sum,
    output logic carry
);

    assign sum   = a ^ b;
    assign carry = a & b;

endmodule

// File: rtl/full_adder_using_half_adders.sv
// Ripple-carry adder of WIDTH bits, each bit a pair of half adders.
// Sum/Carry are purely combinational; Sum_q/Carry_q are a registered copy.
module full_adder_using_half_adders
    import full_adder_using_half_adders_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             C,
    output logic [WIDTH-1:0] Sum,
    output logic             Carry,
    output logic [WIDTH-1:0] Sum_q,
    output logic             Carry_q
);

    logic [WIDTH:0]   cin;
    logic [WIDTH-1:0] s1;
    logic [WIDTH-1:0] c1;
    logic [WIDTH-1:0] c2;

    assign cin[0] = C;

    // Bit i: first half adder combines the operands, second folds in the ripple carry.
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        half_adder u_ha_ab (
            .a     (A[i]),
            .b     (B[i]),
            .sum   (s1[i]),
            .carry (c1[i])
        );

        half_adder u_ha_cin (
            .a     (s1[i]),
            .b     (cin[i]),
            .sum   (Sum[i]),
            .carry (c2[i])
        );

        assign cin[i+1] = c1[i] | c2[i];
    end

    assign Carry = cin[WIDTH];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            Sum_q   <= '0;
            Carry_q <= 1'b0;
        end else begin
            Sum_q   <= Sum;
            Carry_q <= Carry;
        end
    end

endmodule

// File: tb/tb_full_adder_using_half_adders.sv
// Directed bench for the half-adder based adder at WIDTH=1 and WIDTH=4.
module tb_full_adder_using_half_adders;

    logic       clk;
    logic       rst_n;
    logic       a1, b1, c1;
    logic       sum1, carry1, sum1_q, carry1_q;
    logic [3:0] a4, b4;
    logic       c4;
    logic [3:0] sum4, sum4_q;
    logic       carry4, carry4_q;

    int total = 0;
    int bad   = 0;
    logic [4:0] exp_q[$];

    full_adder_using_half_adders #(.WIDTH(1)) dut1 (
        .clk     (clk),
        .rst_n   (rst_n),
        .A       (a1),
        .B       (b1),
        .C       (c1),
        .Sum     (sum1),
        .Carry   (carry1),
        .Sum_q   (sum1_q),
        .Carry_q (carry1_q)
    );

    full_adder_using_half_adders #(.WIDTH(4)) dut4 (
        .clk     (clk),
        .rst_n   (rst_n),
        .A       (a4),
        .B       (b4),
        .C       (c4),
        .Sum     (sum4),
        .Carry   (carry4),
        .Sum_q   (sum4_q),
        .Carry_q (carry4_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        logic [2:0] v;
        logic [4:0] e;
        rst_n = 1'b0;
        a1 = 1'b0; b1 = 1'b0; c1 = 1'b0;
        a4 = 4'h0; b4 = 4'h0; c4 = 1'b0;

        // Exhaustive 1-bit table with hand-computed expectations {carry,sum}.
        exp_q = '{5'b00, 5'b01, 5'b01, 5'b10, 5'b01, 5'b10, 5'b10, 5'b11};
        for (int i = 0; i < 8; i++) begin
            v = 3'(i);
            {a1, b1, c1} = v;
            #1;
            e = exp_q.pop_front();
            check($sformatf("w1_sum_%0d", i), {7'b0, sum1}, {7'b0, e[0]});
            check($sformatf("w1_carry_%0d", i), {7'b0, carry1}, {7'b0, e[1]});
        end

        // 4-bit directed: full-chain ripple and no-carry pattern.
        a4 = 4'hF; b4 = 4'h0; c4 = 1'b1; #1;
        check("w4_ripple_sum", {4'b0, sum4}, 8'h00);
        check("w4_ripple_carry", {7'b0, carry4}, 8'h01);
        a4 = 4'h5; b4 = 4'hA; c4 = 1'b0; #1;
        check("w4_5a_sum", {4'b0, sum4}, 8'h0F);
        check("w4_5a_carry", {7'b0, carry4}, 8'h00);
        a4 = 4'hF; b4 = 4'hF; c4 = 1'b1; #1;
        check("w4_max", {3'b0, carry4, sum4}, 8'h1F);
        a4 = 4'h0; b4 = 4'h0; c4 = 1'b0; #1;
        check("w4_zero", {3'b0, carry4, sum4}, 8'h00);

        // 4-bit random against plain integer addition.
        for (int i = 0; i < 1000; i++) begin
            a4 = 4'($urandom_range(0, 15));
            b4 = 4'($urandom_range(0, 15));
            c4 = 1'($urandom_range(0, 1));
            exp_q.push_back(5'(a4) + 5'(b4) + 5'(c4));
            #1;
            e = exp_q.pop_front();
            check("w4_rand", {3'b0, carry4, sum4}, {3'b0, e});
        end

        // Registered path: two reset edges clear the copies.
        @(negedge clk);
        a1 = 1'b1; b1 = 1'b1; c1 = 1'b1;
        rst_n = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        check("rst_sum_q", {7'b0, sum1_q}, 8'h00);
        check("rst_carry_q", {7'b0, carry1_q}, 8'h00);
        check("rst_w4_q", {3'b0, carry4_q, sum4_q}, 8'h00);

        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("pre_edge_sum_q", {7'b0, sum1_q}, 8'h00);
        check("pre_edge_carry_q", {7'b0, carry1_q}, 8'h00);
        check("comb_sum_111", {7'b0, sum1}, 8'h01);
        @(posedge clk); #1;
        check("post_edge_sum_q", {7'b0, sum1_q}, 8'h01);
        check("post_edge_carry_q", {7'b0, carry1_q}, 8'h01);

        // Reset mid-operation: copy holds until the edge, comb path keeps tracking.
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("mid_rst_hold_sum_q", {7'b0, sum1_q}, 8'h01);
        check("mid_rst_comb_sum", {7'b0, sum1}, 8'h01);
        @(posedge clk); #1;
        check("mid_rst_clr_sum_q", {7'b0, sum1_q}, 8'h00);
        check("mid_rst_clr_carry_q", {7'b0, carry1_q}, 8'h00);
        check("mid_rst_comb_carry", {7'b0, carry1}, 8'h01);
        a1 = 1'b1; b1 = 1'b0; c1 = 1'b0; #1;
        check("rst_low_comb_100", {6'b0, carry1, sum1}, 8'h01);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
